// File: rtl/best_time_pkg.sv
// Shared types, digit offsets and BCD time helpers for the best-time table.
package best_time_pkg;

  localparam int HR10  = 20;
  localparam int HR1   = 16;
  localparam int MIN10 = 12;
  localparam int MIN1  = 8;
  localparam int SEC10 = 4;
  localparam int SEC1  = 0;

  localparam logic [23:0] INIT_BCD_DEF = 24'h595959;
  localparam int          SEC_W_DEF    = 19;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_SCAN   = 2'd2,
    S_INSERT = 2'd3
  } state_t;

  typedef struct packed {
    logic [23:0]          bcd;
    logic [SEC_W_DEF-1:0] total;
    logic                 valid;
  } entry_t;

  function automatic logic bcd_valid(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < 24; p += 4) begin
      ok = ok & (t[p +: 4] <= 4'd9);
    end
    ok = ok & (t[MIN10 +: 4] <= 4'd5) & (t[SEC10 +: 4] <= 4'd5);
    return ok;
  endfunction

  function automatic logic [SEC_W_DEF-1:0] bcd_to_sec(input logic [23:0] t);
    logic [SEC_W_DEF-1:0] hr;
    logic [SEC_W_DEF-1:0] mn;
    logic [SEC_W_DEF-1:0] sc;
    hr = SEC_W_DEF'(t[HR10 +: 4]) * SEC_W_DEF'(4'd10) + SEC_W_DEF'(t[HR1 +: 4]);
    mn = SEC_W_DEF'(t[MIN10 +: 4]) * SEC_W_DEF'(4'd10) + SEC_W_DEF'(t[MIN1 +: 4]);
    sc = SEC_W_DEF'(t[SEC10 +: 4]) * SEC_W_DEF'(4'd10) + SEC_W_DEF'(t[SEC1 +: 4]);
    return hr * SEC_W_DEF'(12'd3600) + mn * SEC_W_DEF'(6'd60) + sc;
  endfunction

endpackage

// File: rtl/best_time_board_bcd_time_to_sec.sv
// Combinational BCD hh:mm:ss validity check and conversion to total seconds.
module bcd_time_to_sec
  import best_time_pkg::*;
#(
  parameter int SEC_W = SEC_W_DEF
) (
  input  logic [23:0]      bcd_i,
  output logic             valid_o,
  output logic [SEC_W-1:0] sec_o
);

  assign valid_o = bcd_valid(bcd_i);
  assign sec_o   = SEC_W'(bcd_to_sec(bcd_i));

endmodule

// File: rtl/best_time_board.sv
// Sorted table of the DEPTH fastest run times, filled by a capture/scan/insert
// sequencer on each rising edge of win, with a registered leaderboard read port.
module best_time_board
  import best_time_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [23:0] INIT_BCD = INIT_BCD_DEF,
  parameter int          SEC_W    = SEC_W_DEF,
  localparam int         IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             win,
  input  logic [23:0]      time_bcd,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [23:0]      rd_bcd,
  output logic             rd_valid,
  output logic [23:0]      best_bcd,
  output logic             busy,
  output logic             inserted,
  output logic             new_record,
  output logic [IDX_W-1:0] rank,
  output logic             err
);

  localparam logic [SEC_W_DEF-1:0] INIT_SEC = bcd_to_sec(INIT_BCD);
  localparam entry_t INIT_ENTRY = '{bcd: INIT_BCD, total: INIT_SEC, valid: 1'b0};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  entry_t           entries_q [DEPTH];
  state_t           state_q;
  logic             win_q;
  logic [23:0]      cap_bcd_q;
  logic [SEC_W-1:0] new_total_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rank_q;
  logic             busy_q;
  logic             inserted_q;
  logic             new_record_q;
  logic             err_q;
  logic [23:0]      rd_bcd_q;
  logic             rd_valid_q;
  logic [23:0]      best_bcd_q;

  logic             capture_s;
  logic             conv_valid_s;
  logic [SEC_W-1:0] conv_sec_s;
  logic             rd_hit_s;

  assign capture_s = win & ~win_q;
  assign rd_hit_s  = (int'(rd_idx) < DEPTH);

  bcd_time_to_sec #(.SEC_W(SEC_W)) u_conv (
    .bcd_i   (cap_bcd_q),
    .valid_o (conv_valid_s),
    .sec_o   (conv_sec_s)
  );

  // Win edge history and registered read/display ports.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      win_q      <= 1'b0;
      rd_bcd_q   <= INIT_BCD;
      rd_valid_q <= 1'b0;
      best_bcd_q <= INIT_BCD;
    end else begin
      win_q      <= win;
      best_bcd_q <= entries_q[0].bcd;
      if (rd_hit_s) begin
        rd_bcd_q   <= entries_q[rd_idx].bcd;
        rd_valid_q <= entries_q[rd_idx].valid;
      end else begin
        rd_bcd_q   <= INIT_BCD;
        rd_valid_q <= 1'b0;
      end
    end
  end

  // Capture / convert / scan / insert sequencer owning the table.
  always_ff @(posedge clk_100MHz) begin
    if (reset || clear) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      inserted_q   <= 1'b0;
      new_record_q <= 1'b0;
      err_q        <= 1'b0;
      rank_q       <= '0;
      idx_q        <= '0;
      cap_bcd_q    <= INIT_BCD;
      new_total_q  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        entries_q[j] <= INIT_ENTRY;
      end
    end else begin
      inserted_q   <= 1'b0;
      new_record_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (capture_s) begin
            cap_bcd_q <= time_bcd;
            busy_q    <= 1'b1;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          if (conv_valid_s) begin
            new_total_q <= conv_sec_s;
            idx_q       <= '0;
            state_q     <= S_SCAN;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SCAN: begin
          // Strict compare: equal times rank below the existing entry.
          if (SEC_W_DEF'(new_total_q) < entries_q[idx_q].total) begin
            state_q <= S_INSERT;
          end else if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_INSERT: begin
          for (int j = 1; j < DEPTH; j++) begin
            if (IDX_W'(j) > idx_q) begin
              entries_q[j] <= entries_q[j-1];
            end
          end
          entries_q[idx_q] <= '{bcd: cap_bcd_q, total: SEC_W_DEF'(new_total_q), valid: 1'b1};
          rank_q       <= idx_q;
          inserted_q   <= 1'b1;
          new_record_q <= (idx_q == '0);
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_bcd     = rd_bcd_q;
  assign rd_valid   = rd_valid_q;
  assign best_bcd   = best_bcd_q;
  assign busy       = busy_q;
  assign inserted   = inserted_q;
  assign new_record = new_record_q;
  assign rank       = rank_q;
  assign err        = err_q;

endmodule

// File: tb/tb_best_time_board.sv
// Randomized and directed bench for best_time_board against a queue-based
// leaderboard model working in plain integer seconds.
module tb_best_time_board;

  localparam int DEPTH    = 4;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [23:0] INIT_T = 24'h595959;
  localparam int INIT_SEC = 59 * 3600 + 59 * 60 + 59;

  logic             clk_100MHz = 1'b0;
  logic             reset;
  logic             win;
  logic [23:0]      time_bcd;
  logic             clear;
  logic [IDX_W-1:0] rd_idx;
  logic [23:0]      rd_bcd;
  logic             rd_valid;
  logic [23:0]      best_bcd;
  logic             busy;
  logic             inserted;
  logic             new_record;
  logic [IDX_W-1:0] rank;
  logic             err;

  best_time_board #(.DEPTH(DEPTH)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .win        (win),
    .time_bcd   (time_bcd),
    .clear      (clear),
    .rd_idx     (rd_idx),
    .rd_bcd     (rd_bcd),
    .rd_valid   (rd_valid),
    .best_bcd   (best_bcd),
    .busy       (busy),
    .inserted   (inserted),
    .new_record (new_record),
    .rank       (rank),
    .err        (err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int          sec;
    logic [23:0] bcd;
  } rec_t;

  rec_t board[$];
  int   m_rank;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_sec(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600
         + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60
         + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic bit m_ok(input logic [23:0] t);
    for (int p = 0; p < 6; p++) begin
      if (int'(t[p*4 +: 4]) > 9) return 1'b0;
    end
    return (int'(t[15:12]) <= 5) && (int'(t[7:4]) <= 5);
  endfunction

  // Apply one finished run to the model; returns the externally visible effects.
  task automatic model_apply(input logic [23:0] t, output int e_busy, output int e_ins,
                             output int e_rec, output int e_err);
    int s;
    int i;
    e_ins = 0; e_rec = 0; e_err = 0;
    if (!m_ok(t)) begin
      e_busy = 1;
      e_err  = 1;
      return;
    end
    s = m_sec(t);
    i = 0;
    while (i < board.size() && board[i].sec <= s) i++;
    if (i < DEPTH && s < INIT_SEC) begin
      board.insert(i, '{sec: s, bcd: t});
      if (board.size() > DEPTH) void'(board.pop_back());
      m_rank = i;
      e_ins  = 1;
      e_rec  = (i == 0) ? 1 : 0;
      e_busy = 3 + i;
    end else begin
      e_busy = 1 + DEPTH;
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_100MHz);
      rd_idx = IDX_W'(i);
      @(negedge clk_100MHz);
      check_val($sformatf("%s rd_bcd[%0d]", tag, i), rd_bcd,
                (i < board.size()) ? board[i].bcd : INIT_T);
      check_val($sformatf("%s rd_valid[%0d]", tag, i), rd_valid, (i < board.size()) ? 1 : 0);
    end
    check_val({tag, " best_bcd"}, best_bcd, (board.size() > 0) ? board[0].bcd : INIT_T);
    check_val({tag, " rank"}, rank, m_rank);
    check_val({tag, " busy_idle"}, busy, 0);
  endtask

  // Raise win with time t for hold cycles; bounce drops and re-raises win mid-run.
  task automatic do_run(input logic [23:0] t, input int hold, input bit bounce, input string tag);
    int b_n, i_n, r_n, e_n;
    int e_busy, e_ins, e_rec, e_err;
    b_n = 0; i_n = 0; r_n = 0; e_n = 0;
    @(negedge clk_100MHz);
    time_bcd = t;
    win = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk_100MHz);
      b_n += int'(busy);
      i_n += int'(inserted);
      r_n += int'(new_record);
      e_n += int'(err);
      if (bounce && c == 0) win = 1'b0;
      if (bounce && c == 1) win = 1'b1;
    end
    win = 1'b0;
    model_apply(t, e_busy, e_ins, e_rec, e_err);
    check_val({tag, " busy_cycles"}, b_n, e_busy);
    check_val({tag, " inserted"}, i_n, e_ins);
    check_val({tag, " new_record"}, r_n, e_rec);
    check_val({tag, " err"}, e_n, e_err);
    check_table(tag);
  endtask

  task automatic clear_idle();
    @(negedge clk_100MHz);
    clear = 1'b1;
    @(negedge clk_100MHz);
    clear = 1'b0;
    board.delete();
    m_rank = 0;
    check_table("clear_idle");
  endtask

  function automatic logic [23:0] rand_valid();
    logic [23:0] t;
    t[23:20] = 4'd0;
    t[19:16] = 4'($urandom_range(0, 1));
    t[15:12] = 4'($urandom_range(0, 5));
    t[11:8]  = 4'($urandom_range(0, 9));
    t[7:4]   = 4'($urandom_range(0, 5));
    t[3:0]   = 4'($urandom_range(0, 9));
    return t;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int b_n, i_n;
    logic [23:0] t;
    reset = 1'b1; clear = 1'b0; win = 1'b0; time_bcd = 24'h000000; rd_idx = '0;
    m_rank = 0;
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    check_val("reset inserted", inserted, 0);
    check_val("reset err", err, 0);
    check_table("reset");

    do_run(24'h000130, DEPTH + 6, 1'b0, "first");
    do_run(24'h000200, DEPTH + 6, 1'b0, "ins_200");
    do_run(24'h000100, DEPTH + 6, 1'b0, "ins_100");
    do_run(24'h000145, DEPTH + 6, 1'b0, "ins_145");
    do_run(24'h000130, DEPTH + 6, 1'b0, "tie_130");
    do_run(24'h001000, DEPTH + 6, 1'b0, "too_slow");
    do_run(24'h0001A0, DEPTH + 6, 1'b0, "bad_digit");
    do_run(24'h000160, DEPTH + 6, 1'b0, "bad_sec10");
    do_run(24'h000030, 50, 1'b0, "hold50");
    do_run(24'h000140, DEPTH + 6, 1'b1, "bounce");

    // Abort a run in SCAN with clear; nothing may be written or pulsed.
    b_n = 0; i_n = 0;
    @(negedge clk_100MHz);
    time_bcd = 24'h000050;
    win = 1'b1;
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    clear = 1'b1;
    @(negedge clk_100MHz);
    clear = 1'b0;
    win = 1'b0;
    for (int c = 0; c < DEPTH + 6; c++) begin
      b_n += int'(busy);
      i_n += int'(inserted) + int'(new_record) + int'(err);
      @(negedge clk_100MHz);
    end
    check_val("clr_scan busy", b_n, 0);
    check_val("clr_scan pulses", i_n, 0);
    board.delete();
    m_rank = 0;
    check_table("clr_scan");
    do_run(24'h000005, DEPTH + 6, 1'b0, "after_clr");
    do_run(24'h595959, DEPTH + 6, 1'b0, "sentinel");

    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 1) begin
        clear_idle();
      end else begin
        if (kind == 0) t = 24'($urandom());
        else if (kind == 2 && board.size() > 0) t = board[$urandom_range(0, board.size() - 1)].bcd;
        else if (kind == 3) t = 24'h595959 - 24'($urandom_range(0, 1));
        else t = rand_valid();
        do_run(t, $urandom_range(DEPTH + 6, DEPTH + 12),
               m_ok(t) ? 1'($urandom_range(0, 1)) : 1'b0, $sformatf("rnd%0d", n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
